// File: rtl/pio_arbiter_pkg.sv
// Shared types and helpers for the PIO register-port arbiter.
package pio_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  // The PIO returns registered read data one cycle after its read strobe.
  localparam int unsigned cSLAVE_LATENCY = 1;
  localparam int unsigned cMAX_MASTERS   = 8;

  // One-hot round-robin pick: first set bit after 'last', wrapping modulo n.
  function automatic logic [cMAX_MASTERS-1:0] next_rr(input logic [cMAX_MASTERS-1:0] req,
                                                      input int unsigned last,
                                                      input int unsigned n);
    int unsigned idx;
    next_rr = '0;
    for (int unsigned i = 1; i <= n; i++) begin
      idx = (last + i) % n;
      if (req[idx] && (next_rr == '0)) next_rr[idx] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/pio_arbiter_if.sv
// Master-side Avalon-MM bundle plus PIO-side strobes for pio_arbiter.
interface pio_arbiter_if #(
  parameter int unsigned pMASTERS   = 4,
  parameter int unsigned pADDR_BITS = 4,
  parameter int unsigned pDATA_BITS = 32
);
  logic [pMASTERS*pADDR_BITS-1:0] iM_ADDRESS;
  logic [pMASTERS-1:0]            iM_WRITE;
  logic [pMASTERS-1:0]            iM_READ;
  logic [pMASTERS*pDATA_BITS-1:0] iM_WRITE_DATA;
  logic [pMASTERS-1:0]            oM_WAIT_REQUEST;
  logic [pMASTERS-1:0]            oM_READ_VALID;
  logic [pDATA_BITS-1:0]          oM_READ_DATA;
  logic [pADDR_BITS-1:0]          oADDRESS;
  logic                           oWRITE;
  logic                           oREAD;
  logic [pDATA_BITS-1:0]          oWRITE_DATA;
  logic [pDATA_BITS-1:0]          iREAD_DATA;

  // Arbiter's view: slave to the masters, driver of the PIO port.
  modport slave (
    input  iM_ADDRESS, iM_WRITE, iM_READ, iM_WRITE_DATA, iREAD_DATA,
    output oM_WAIT_REQUEST, oM_READ_VALID, oM_READ_DATA,
    output oADDRESS, oWRITE, oREAD, oWRITE_DATA
  );

  // Environment's view: the requesting masters and the PIO itself.
  modport master (
    output iM_ADDRESS, iM_WRITE, iM_READ, iM_WRITE_DATA, iREAD_DATA,
    input  oM_WAIT_REQUEST, oM_READ_VALID, oM_READ_DATA,
    input  oADDRESS, oWRITE, oREAD, oWRITE_DATA
  );
endinterface

// File: rtl/pio_arbiter_rr_grant.sv
// Combinational round-robin grant: rotate requests past the last grant, pick the
// lowest set bit, rotate the index back.
module rr_grant #(
  parameter int unsigned pN = 4
) (
  input  logic [pN-1:0]          iReq,
  input  logic [$clog2(pN)-1:0]  iLast,
  output logic [pN-1:0]          oGrant,
  output logic [$clog2(pN)-1:0]  oGrantIdx
);
  localparam int unsigned cIDX_BITS = $clog2(pN);

  logic [2*pN-1:0] doubled;
  logic [pN-1:0]   rotated;
  logic            found;
  int              offset;
  int              sum;

  always_comb begin
    doubled = {iReq, iReq};
    rotated = pN'(doubled >> (int'(iLast) + 1));
    found   = 1'b0;
    offset  = 0;
    for (int i = 0; i < int'(pN); i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end
    sum = int'(iLast) + 1 + offset;
    if (sum >= int'(pN)) sum = sum - int'(pN);
    oGrantIdx = found ? cIDX_BITS'(sum) : '0;
    oGrant    = '0;
    if (found) oGrant[oGrantIdx] = 1'b1;
  end

endmodule

// File: rtl/pio_arbiter.sv
// Round-robin arbiter sharing one single-cycle PIO register port among several
// Avalon-MM masters; one whole transfer at a time, all outputs registered.
module pio_arbiter
  import pio_arbiter_pkg::*;
#(
  parameter int unsigned pMASTERS   = 4,
  parameter int unsigned pADDR_BITS = 4,
  parameter int unsigned pDATA_BITS = 32
) (
  input logic          iCLK,
  input logic          iRESETn,
  pio_arbiter_if.slave bus
);
  localparam int unsigned cIDX_BITS = $clog2(pMASTERS);

  logic [pMASTERS-1:0]   req;
  logic [pMASTERS-1:0]   grantOneHot;
  logic [cIDX_BITS-1:0]  grantIdx;

  state_e                state;
  logic [cIDX_BITS-1:0]  lastGrant;  // also the owner of the transfer in flight
  logic [pMASTERS-1:0]   waitReq;
  logic [pMASTERS-1:0]   readValid;
  logic [pDATA_BITS-1:0] readData;
  logic [pADDR_BITS-1:0] address;
  logic [pDATA_BITS-1:0] writeData;
  logic                  write;
  logic                  read;

  assign req = bus.iM_WRITE | bus.iM_READ;

  rr_grant #(
    .pN(pMASTERS)
  ) uGrant (
    .iReq     (req),
    .iLast    (lastGrant),
    .oGrant   (grantOneHot),
    .oGrantIdx(grantIdx)
  );

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state     <= IDLE;
      lastGrant <= cIDX_BITS'(pMASTERS - 1);
      waitReq   <= '1;
      readValid <= '0;
      readData  <= '0;
      address   <= '0;
      writeData <= '0;
      write     <= 1'b0;
      read      <= 1'b0;
    end else begin
      write     <= 1'b0;
      read      <= 1'b0;
      readValid <= '0;
      waitReq   <= '1;
      unique case (state)
        IDLE: begin
          if (|req) begin
            lastGrant <= grantIdx;
            address   <= bus.iM_ADDRESS[grantIdx*pADDR_BITS +: pADDR_BITS];
            writeData <= bus.iM_WRITE_DATA[grantIdx*pDATA_BITS +: pDATA_BITS];
            // Write wins when a master raises both strobes.
            write     <= bus.iM_WRITE[grantIdx];
            read      <= !bus.iM_WRITE[grantIdx];
            waitReq   <= ~grantOneHot;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= write ? IDLE : RDWAIT;
        RDWAIT: begin
          readData             <= bus.iREAD_DATA;
          readValid[lastGrant] <= 1'b1;
          state                <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oM_WAIT_REQUEST = waitReq;
  assign bus.oM_READ_VALID   = readValid;
  assign bus.oM_READ_DATA    = readData;
  assign bus.oADDRESS        = address;
  assign bus.oWRITE_DATA     = writeData;
  assign bus.oWRITE          = write;
  assign bus.oREAD           = read;

endmodule

// File: tb/tb_pio_arbiter.sv
// Scoreboard bench for pio_arbiter: randomized masters, a PIO register model and a
// transaction-level round-robin reference.
module tb_pio_arbiter;
  localparam int M  = 4;
  localparam int AB = 4;
  localparam int DB = 32;

  typedef struct {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
    bit            wr;
    bit            rd;
  } txn_t;

  typedef struct {
    int            m;
    logic [DB-1:0] data;
    longint        due;
  } rdexp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  pio_arbiter_if #(.pMASTERS(M), .pADDR_BITS(AB), .pDATA_BITS(DB)) bus ();

  pio_arbiter #(.pMASTERS(M), .pADDR_BITS(AB), .pDATA_BITS(DB)) dut (
    .iCLK   (clk),
    .iRESETn(rstn),
    .bus    (bus)
  );

  initial forever #5 clk = ~clk;

  txn_t          expQ[M][$];
  txn_t          forcedQ[M][$];
  rdexp_t        readQ[$];
  int            grantLog[$];
  logic [DB-1:0] pioMem[16];
  logic [DB-1:0] shadow[16];
  bit            active[M];
  bit            releasePending[M];
  int            prob[M];
  int            opMode;
  bit            genEn;
  longint        cyc;
  longint        earliest;
  int            lastModel;
  int            checks;
  int            passes;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic txn_t mk(input logic [AB-1:0] a, input logic [DB-1:0] d,
                              input bit wr, input bit rd);
    txn_t t;
    t.addr = a;
    t.data = d;
    t.wr   = wr;
    t.rd   = rd;
    return t;
  endfunction

  // Reference arbitration: first requester after the previous winner, wrapping.
  function automatic int rrPick(input logic [M-1:0] req, input int last);
    for (int i = 1; i <= M; i++) begin
      if (req[(last + i) % M]) return (last + i) % M;
    end
    return 0;
  endfunction

  // PIO register file: registered read data one cycle after the read strobe.
  initial begin
    for (int i = 0; i < 16; i++) pioMem[i] = 32'hA5A5_0000 | DB'(i);
    forever begin
      @(posedge clk);
      if (bus.oWRITE) pioMem[bus.oADDRESS] = bus.oWRITE_DATA;
      bus.iREAD_DATA <= bus.oREAD ? pioMem[bus.oADDRESS] : DB'($urandom);
    end
  end

  // Masters: hold each request until waitrequest is seen low, then free the slot.
  initial begin
    txn_t t;
    bit   go;
    int   r;
    forever begin
      @(negedge clk);
      for (int k = 0; k < M; k++) begin
        if (releasePending[k]) begin
          releasePending[k] = 1'b0;
          active[k]         = 1'b0;
          bus.iM_WRITE[k]   = 1'b0;
          bus.iM_READ[k]    = 1'b0;
        end else if (active[k] && rstn && !bus.oM_WAIT_REQUEST[k]) begin
          releasePending[k] = 1'b1;
        end
        if (!active[k]) begin
          go = 1'b0;
          if (forcedQ[k].size() > 0) begin
            t  = forcedQ[k].pop_front();
            go = 1'b1;
          end else if (genEn && (int'($urandom_range(99)) < prob[k])) begin
            t.addr = AB'($urandom);
            t.data = $urandom;
            r = (opMode == 1) ? 0 : (opMode == 2) ? 1 : int'($urandom_range(3));
            t.wr = (r == 0) || (r == 2);
            t.rd = (r != 0);
            go = 1'b1;
          end
          if (go) begin
            active[k]                       = 1'b1;
            bus.iM_ADDRESS[k*AB +: AB]      = t.addr;
            bus.iM_WRITE_DATA[k*DB +: DB]   = t.data;
            bus.iM_WRITE[k]                 = t.wr;
            bus.iM_READ[k]                  = t.rd;
            expQ[k].push_back(t);
          end
        end
      end
    end
  end

  // Monitor: predicts every cycle's PIO strobe, waitrequest and read return.
  initial begin
    logic [M-1:0] reqNow;
    logic [M-1:0] expWait;
    bit           expectStrobe;
    int           g;
    txn_t         t;
    rdexp_t       r;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rstn) begin
        earliest  = cyc + 1;
        lastModel = M - 1;
        readQ.delete();
        chk("reset_waitreq", bus.oM_WAIT_REQUEST, {M{1'b1}});
        chk("reset_strobes", {bus.oWRITE, bus.oREAD}, 2'b00);
        chk("reset_valid", bus.oM_READ_VALID, '0);
        chk("reset_rdata", bus.oM_READ_DATA, '0);
        chk("reset_addr", bus.oADDRESS, '0);
        chk("reset_wdata", bus.oWRITE_DATA, '0);
      end else begin
        reqNow       = bus.iM_WRITE | bus.iM_READ;
        expectStrobe = (cyc >= earliest) && (reqNow != '0);
        chk("strobe_timing", bus.oWRITE | bus.oREAD, expectStrobe);
        chk("strobe_exclusive", bus.oWRITE & bus.oREAD, 1'b0);
        if (expectStrobe) begin
          g         = rrPick(reqNow, lastModel);
          lastModel = g;
          grantLog.push_back(g);
          chk("expq_nonempty", expQ[g].size() != 0, 1'b1);
          if (expQ[g].size() != 0) begin
            t       = expQ[g].pop_front();
            expWait = '1;
            expWait[g] = 1'b0;
            chk("waitreq_grant", bus.oM_WAIT_REQUEST, expWait);
            chk("slave_op", {bus.oWRITE, bus.oREAD}, {t.wr, !t.wr});
            chk("slave_addr", bus.oADDRESS, t.addr);
            if (t.wr) begin
              chk("slave_wdata", bus.oWRITE_DATA, t.data);
              shadow[t.addr] = t.data;
              earliest       = cyc + 2;
            end else begin
              r.m    = g;
              r.data = shadow[t.addr];
              r.due  = cyc + 2;
              readQ.push_back(r);
              earliest = cyc + 3;
            end
          end
        end else begin
          chk("waitreq_idle", bus.oM_WAIT_REQUEST, {M{1'b1}});
        end
        if ((readQ.size() > 0) && (readQ[0].due == cyc)) begin
          r = readQ.pop_front();
          expWait = '0;
          expWait[r.m] = 1'b1;
          chk("read_valid", bus.oM_READ_VALID, expWait);
          chk("read_data", bus.oM_READ_DATA, r.data);
        end else begin
          chk("no_read_valid", bus.oM_READ_VALID, '0);
        end
      end
    end
  end

  task automatic drain();
    bit busy;
    genEn = 1'b0;
    busy  = 1'b1;
    for (int i = 0; i < 300 && busy; i++) begin
      @(negedge clk);
      busy = (readQ.size() != 0);
      for (int k = 0; k < M; k++) begin
        if (active[k] || (expQ[k].size() != 0) || (forcedQ[k].size() != 0)) busy = 1'b1;
      end
    end
    chk("drain_complete", busy, 1'b0);
  endtask

  initial begin
    int  start;
    bit  seen;
    bus.iM_ADDRESS    = '0;
    bus.iM_WRITE      = '0;
    bus.iM_READ       = '0;
    bus.iM_WRITE_DATA = '0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'hA5A5_0000 | DB'(i);
    for (int k = 0; k < M; k++) prob[k] = 0;
    genEn = 1'b0;
    opMode = 0;
    lastModel = M - 1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    forcedQ[2].push_back(mk(4'd3, 32'h0000_00F0, 1'b1, 1'b0));
    drain();
    forcedQ[1].push_back(mk(4'd1, 32'h0, 1'b0, 1'b1));
    drain();

    // All masters streaming writes: must rotate strictly.
    start = grantLog.size();
    opMode = 1;
    for (int k = 0; k < M; k++) prob[k] = 100;
    genEn = 1'b1;
    for (int i = 0; i < 1000 && grantLog.size() < start + 100; i++) @(negedge clk);
    drain();
    chk("rotation_count", grantLog.size() >= start + 100, 1'b1);
    for (int i = start + 1; i < grantLog.size(); i++)
      chk("rotation_order", grantLog[i], (grantLog[i-1] + 1) % M);

    // A lone continuous requester wins every transfer.
    start = grantLog.size();
    opMode = 0;
    for (int k = 0; k < M; k++) prob[k] = (k == 1) ? 100 : 0;
    genEn = 1'b1;
    repeat (40) @(negedge clk);
    drain();
    chk("single_count", grantLog.size() > start, 1'b1);
    for (int i = start; i < grantLog.size(); i++) chk("single_master", grantLog[i], 1);

    forcedQ[3].push_back(mk(4'd5, 32'h1234_5678, 1'b1, 1'b1));
    drain();

    // Reset in the middle of master 0's read data phase.
    forcedQ[0].push_back(mk(4'd2, 32'h0, 1'b0, 1'b1));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (bus.oREAD && !bus.oM_WAIT_REQUEST[0]) seen = 1'b1;
    end
    chk("rd0_issued", seen, 1'b1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("async_waitreq", bus.oM_WAIT_REQUEST, {M{1'b1}});
    chk("async_strobes", {bus.oWRITE, bus.oREAD}, 2'b00);
    chk("async_valid", bus.oM_READ_VALID, '0);
    forcedQ[2].push_back(mk(4'd7, 32'hCAFE_0002, 1'b1, 1'b0));
    forcedQ[0].push_back(mk(4'd6, 32'hCAFE_0000, 1'b1, 1'b0));
    repeat (3) @(negedge clk);
    start = grantLog.size();
    rstn = 1'b1;
    drain();
    chk("post_reset_count", grantLog.size() >= start + 2, 1'b1);
    if (grantLog.size() > start) chk("post_reset_first", grantLog[start], 0);

    // Randomized mix of masters and operations.
    for (int k = 0; k < M; k++) prob[k] = int'($urandom_range(80, 20));
    opMode = 0;
    genEn = 1'b1;
    repeat (1500) @(negedge clk);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pio_arbiter.md
Name: pio_arbiter

Overview:
Round-robin arbiter that shares one PIO register port among pMASTERS independent bus masters, such as the soft CPU, a JTAG bridge and DMA/sequencer engines.
- Master side: Avalon-MM style with waitrequest and readdatavalid.
- Slave side: drives the PIO's single-cycle write/read strobes and captures its 1-cycle-latency registered read data.
- Serialises accesses so read-modify-write register sequences from different masters never interleave within a single transfer.

Parameters:
pMASTERS, 4, number of requesting masters (2..8)
pADDR_BITS, 4, register address width passed through to the PIO
pDATA_BITS, 32, data width

Ports:
iCLK  in  1  clock
iRESETn  in  1  reset; asynchronous assert, active-low
iM_ADDRESS  in  pMASTERS*pADDR_BITS  per-master address, master k at [k*pADDR_BITS +: pADDR_BITS]
iM_WRITE  in  pMASTERS  per-master write request
iM_READ  in  pMASTERS  per-master read request
iM_WRITE_DATA  in  pMASTERS*pDATA_BITS  per-master write data
oM_WAIT_REQUEST  out  pMASTERS  per-master stall; low for one cycle means accepted
oM_READ_VALID  out  pMASTERS  one-cycle read-data-valid pulse to the owning master
oM_READ_DATA  out  pDATA_BITS  read data shared by all masters, qualified by oM_READ_VALID
oADDRESS  out  pADDR_BITS  to PIO
oWRITE  out  1  to PIO
oREAD  out  1  to PIO
oWRITE_DATA  out  pDATA_BITS  to PIO
iREAD_DATA  in  pDATA_BITS  from PIO, valid the cycle after oREAD

Behaviour:
- Reset (iRESETn low, asynchronous):
  - state=IDLE.
  - oM_WAIT_REQUEST all ones; oM_READ_VALID=0; oM_READ_DATA=0.
  - oADDRESS, oWRITE, oREAD, oWRITE_DATA all 0.
  - last_grant=pMASTERS-1, so master 0 has first priority.
- All outputs are registered.
- Master protocol: a master holds address, data and strobe stable while its oM_WAIT_REQUEST is high.
- Request vector req[k] = iM_WRITE[k] | iM_READ[k].
- IDLE:
  - If req is non-zero, grant the first requesting index scanning last_grant+1, last_grant+2, … with wrap-around modulo pMASTERS.
  - Register the grantee's address, data and op (write if iM_WRITE, else read), set last_grant=grantee, go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE (exactly one cycle):
  - oWRITE or oREAD=1 with the registered address/data; oM_WAIT_REQUEST[grantee]=0, all others stay 1.
  - Write: go to IDLE.
  - Read: go to RDWAIT.
- RDWAIT (one cycle):
  - Capture iREAD_DATA into oM_READ_DATA and assert oM_READ_VALID[grantee] for the following cycle; go to IDLE.
- Latency:
  - Request first visible in IDLE at cycle N: accepted (waitrequest low) and slave strobe at N+1.
  - Read data valid to the master at N+3.
- Throughput:
  - Write occupies 2 cycles; read occupies 3 cycles.
  - Arbitration in IDLE may overlap the read-valid pulse of the previous read.
- Strobes and data:
  - oWRITE and oREAD are never high together and never high for more than one consecutive cycle.
  - oWRITE_DATA and oADDRESS hold their last values when idle.
- Boundary conditions:
  - iM_WRITE and iM_READ both high from one master: treated as a write; the read is dropped and no oM_READ_VALID is generated.
  - A master dropping its request before acceptance is a protocol violation; a request sampled in IDLE still completes from the registered copy.
  - All masters requesting continuously: strict rotation 0,1,2,3,0,…; no master starves (worst-case wait is pMASTERS-1 transfers).
  - A single master requesting continuously: it is granted every transfer.
  - Reset asserted mid-ISSUE or mid-RDWAIT: transfer abandoned; no valid pulse after reset release; strobes drop immediately.
- oM_READ_VALID is one-hot or zero.

Decomposition:
- Package pio_arbiter_pkg:
  - state enum {IDLE, ISSUE, RDWAIT} (2 bits).
  - Localparam for the slave read latency (=1).
  - Function next_rr(req, last) returning a one-hot grant.
- One sub-module rr_grant: combinational rotate, priority-encode, rotate back.
  - Parameter pN; inputs req and last index; outputs one-hot grant and grant index.
  - Reusable by other shared-peripheral arbiters.

Test Plan:
- Reset, no requests -> oM_WAIT_REQUEST=4'b1111, oWRITE=oREAD=0, oM_READ_VALID=0 for 20 cycles.
- Master 2 writes addr 3, data 0x0000_00F0 -> oWRITE high exactly one cycle with oADDRESS=3, oWRITE_DATA=0xF0; oM_WAIT_REQUEST[2] low that same cycle; completes 2 cycles after request.
- Master 1 reads addr 1, PIO model returns 0xA5A5_0001 one cycle after oREAD -> oM_READ_VALID=4'b0010 with oM_READ_DATA=0xA5A5_0001 exactly 3 cycles after request; no other valid bits set.
- All four masters issue back-to-back writes with distinct data -> slave sees order 0,1,2,3,0,1,… with no lost or duplicated transfers over 100 transfers.
- Master 3 holds read with write also high -> single write issued; no read strobe; no valid pulse.
- Assert iRESETn low during RDWAIT of master 0's read -> outputs return to reset values asynchronously; no oM_READ_VALID after release; next request is arbitrated starting from master 0.
